bch_decoder_15_7: RTL
=====================

// Module: bch_decoder_15_7
// PURPOSE
// - Receive-side counterpart of the BCH encoder. Encoder produces c(x)=m(x)*g(x), a non-systematic code.
// - Block takes one 15-bit received word and computes syndromes S1, S3 over GF(16) with primitive poly x^4+x+1.
// - Solves the t=2 error locator (Peterson), runs a serial Chien search, corrects up to 2 bit errors.
// - Recovers the 7-bit message by serial long division by g(x). Sits after the noise/error-injection stage.
// PARAMETERS
// - GEN_POLY         9'h1D1  g(x)=x^8+x^7+x^6+x^4+1, bit i = coeff of x^i
// - PRIM_POLY        5'h13   GF(16) field poly x^4+x+1
// - PASS_RAW_ON_FAIL 1       1: on failure emit quotient of uncorrected word; 0: emit 7'h00
// PORTS
// - clk            in   1   system clock
// - rst            in   1   asynchronous, active-high reset
// - in_valid       in   1   cw_in valid
// - in_ready       out  1   decoder can accept (high only in IDLE)
// - cw_in          in   15  received word, bit i = coeff of x^i
// - out_valid      out  1   result valid, held until taken
// - out_ready      in   1   consumer accepts result
// - msg_out        out  7   decoded message m(x)
// - err_cnt        out  2   bits corrected (0..2)
// - uncorrectable  out  1   decode failure flag
// BEHAVIOUR
// - Clock/reset: one clock; reset is asynchronous and active-high. All state clears on rst.
// - Reset values: in_ready=0 during rst, 1 in the first cycle after release. out_valid=0, msg_out=0, err_cnt=0, uncorrectable=0.
// - FSM: IDLE -> SYND(15) -> LOCATE(1) -> CHIEN(15) -> DIVIDE(7) -> DONE -> IDLE.
// - IDLE: in_valid&in_ready latches cw_in into r_reg, then moves to SYND. No other state accepts input.
// - SYND: Horner evaluation, MSB (bit14) first.
//   - Each cycle: S1=S1*a ^ r[k]; S3=S3*a^3 ^ r[k].
//   - Both start at 0.
// - LOCATE:
//   - S1=0, S3=0: no error; sig1=sig2=0; expected roots 0.
//   - S1!=0, S3==S1^3: sig1=S1, sig2=0; expected roots 1.
//   - S1!=0, otherwise: sig1=S1, sig2=S3*inv(S1)^S1^2; expected roots 2.
//   - S1=0, S3!=0: set uncorrectable; skip correction in CHIEN.
// - CHIEN: step i=0..14.
//   - Test 1^t1^t2==0 with t1=sig1*a^-i and t2=sig2*a^-2i, updated iteratively by a^14 and a^13.
//   - A root at step i flips r_reg[i] and increments root_cnt.
// - End of CHIEN: root_cnt != expected roots sets uncorrectable.
//   - Flips are undone by reloading the latched raw word; uncorrected copy kept in raw_reg.
// - DIVIDE: 7 MSB-first long-division steps by GEN_POLY.
//   - Produces the quotient q[6:0] and an 8-bit remainder.
//   - Nonzero remainder on a corrected word also sets uncorrectable.
// - DONE: out_valid=1, registered outputs stable.
//   - msg_out = q when decode OK; else PASS_RAW_ON_FAIL ? q(raw) : 0.
//   - err_cnt = root_cnt when OK; 0 on failure.
//   - out_valid&out_ready -> IDLE; out_valid drops next edge.
// - Latency: out_valid rises exactly 38 clock edges after the accepting edge, independent of data.
// - Backpressure: out_ready low holds DONE indefinitely with all outputs frozen.
// - GF arithmetic: 4-bit, pure combinational functions.
//   - Multiply reduces by PRIM_POLY; inverse via 16-entry LUT; inv(0) is never used.
// - Reset mid-operation: aborts immediately to IDLE, all outputs to reset values, no partial result emitted.
// - Sampling: in_valid outside IDLE is ignored. out_ready outside DONE is ignored.
// STRUCTURE
// - bch_pkg holds:
//   - localparams N=15, K=7, GEN_POLY/PRIM_POLY defaults;
//   - gf16_t typedef; gf16_mul, gf16_inv (LUT), gf16_pow_a functions;
//   - bch_dec_state_e enum.
// - Sub-module bch_chien_search: sig1/sig2 in, start, per-step root strobe + index, root count.
// - Rest (syndrome, locate, divider, FSM) lives in the top module.
// TESTING
// - Clean word: cw_in=15'h0000 -> msg_out=7'h00, err_cnt=0, uncorrectable=0, out_valid at accept+38.
// - Clean word: cw_in=15'h01D1 (m=1) -> msg_out=7'h01, err_cnt=0.
// - Single error: cw_in=15'h01D1^15'h0004 -> msg_out=7'h01, err_cnt=1, uncorrectable=0.
// - Double error: cw_in=15'h01D1^15'h4001 -> msg_out=7'h01, err_cnt=2.
// - Triple error: cw_in=15'h01D1^15'h0013 (S1=0, S3!=0) -> uncorrectable=1, err_cnt=0, msg_out=q(raw).
// - Handshake/reset:
//   - out_ready low 5 cycles in DONE -> outputs frozen, in_ready=0.
//   - rst pulse at accept+20 -> out_valid never rises; next word decodes normally.

Source files
------------

// File: rtl/bch_pkg.sv
// Shared types, GF(16) arithmetic and FSM state encoding for the BCH(15,7) decoder.
package bch_pkg;

    localparam int unsigned N = 15;
    localparam int unsigned K = 7;
    localparam logic [8:0] GEN_POLY_DEF  = 9'h1D1;
    localparam logic [4:0] PRIM_POLY_DEF = 5'h13;

    typedef logic [3:0] gf16_t;

    typedef enum logic [2:0] {
        StIdle,
        StSynd,
        StLocate,
        StChien,
        StDivide,
        StDone
    } bch_dec_state_e;

    // Shift-and-add multiply; poly holds the low four field-polynomial coefficients.
    function automatic gf16_t gf16_mul(gf16_t a, gf16_t b, gf16_t poly);
        gf16_t p;
        gf16_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = x[3] ? ({x[2:0], 1'b0} ^ poly) : {x[2:0], 1'b0};
        end
        return p;
    endfunction

    // Inverse table for x^4+x+1; entry 0 is never used.
    function automatic gf16_t gf16_inv(gf16_t a);
        gf16_t r;
        case (a)
            4'h1: r = 4'h1;
            4'h2: r = 4'h9;
            4'h3: r = 4'hE;
            4'h4: r = 4'hD;
            4'h5: r = 4'hB;
            4'h6: r = 4'h7;
            4'h7: r = 4'h6;
            4'h8: r = 4'hF;
            4'h9: r = 4'h2;
            4'hA: r = 4'hC;
            4'hB: r = 4'h5;
            4'hC: r = 4'hA;
            4'hD: r = 4'h4;
            4'hE: r = 4'h3;
            4'hF: r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // alpha^n, used only for elaboration-time constants.
    function automatic gf16_t gf16_pow_a(int unsigned n, gf16_t poly);
        gf16_t p;
        p = 4'h1;
        for (int unsigned i = 0; i < n; i++) begin
            p = gf16_mul(p, 4'h2, poly);
        end
        return p;
    endfunction

endpackage

// File: rtl/bch_chien_search.sv
// Serial Chien search: evaluates 1 + sig1*x + sig2*x^2 at x = a^-i for i = 0..14.
module bch_chien_search
    import bch_pkg::*;
#(
    parameter logic [4:0] PRIM_POLY = PRIM_POLY_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] sig1,
    input  logic [3:0] sig2,
    output logic       root,
    output logic [3:0] idx,
    output logic [1:0] root_cnt
);

    localparam gf16_t POLY = PRIM_POLY[3:0];
    localparam gf16_t A_M1 = gf16_pow_a(14, POLY);  // a^-1
    localparam gf16_t A_M2 = gf16_pow_a(13, POLY);  // a^-2

    logic [3:0] t1_q;
    logic [3:0] t2_q;
    logic [3:0] idx_q;
    logic [1:0] cnt_q;
    logic       busy_q;

    assign root     = busy_q && ((4'h1 ^ t1_q ^ t2_q) == 4'h0);
    assign idx      = idx_q;
    assign root_cnt = cnt_q;

    // Load the locator terms on start, then step them by a^-1 / a^-2 each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t1_q   <= '0;
            t2_q   <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            t1_q   <= sig1;
            t2_q   <= sig2;
            idx_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            t1_q  <= gf16_mul(t1_q, A_M1, POLY);
            t2_q  <= gf16_mul(t2_q, A_M2, POLY);
            idx_q <= idx_q + 4'd1;
            if (root) begin
                cnt_q <= cnt_q + 2'd1;
            end
            if (idx_q == 4'd14) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bch_decoder_15_7.sv
// BCH(15,7) t=2 decoder: syndromes, Peterson locator, Chien correction, division by g(x).
module bch_decoder_15_7
    import bch_pkg::*;
#(
    parameter logic [8:0] GEN_POLY         = GEN_POLY_DEF,
    parameter logic [4:0] PRIM_POLY        = PRIM_POLY_DEF,
    parameter bit         PASS_RAW_ON_FAIL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] cw_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  msg_out,
    output logic [1:0]  err_cnt,
    output logic        uncorrectable
);

    localparam gf16_t       POLY  = PRIM_POLY[3:0];
    localparam gf16_t       A1    = gf16_pow_a(1, POLY);
    localparam gf16_t       A3    = gf16_pow_a(3, POLY);
    localparam logic [14:0] G_TOP = {GEN_POLY, 6'b0};  // g(x) aligned to bit 14

    bch_dec_state_e state_q, state_d;

    logic [3:0]  cnt_q;
    logic [14:0] r_q;     // working word: corrected in CHIEN, dividend in DIVIDE
    logic [14:0] raw_q;   // uncorrected copy; becomes its own dividend in DIVIDE
    gf16_t       s1_q, s3_q;
    logic [1:0]  exp_q;
    logic        fail_q;
    logic [1:0]  err_q;
    logic [6:0]  q_q, qraw_q;
    logic [6:0]  msg_q;
    logic [1:0]  errcnt_q;
    logic        unc_q;

    gf16_t       sig1, sig2, s1_cube;
    logic [1:0]  loc_exp;
    logic        loc_fail;
    logic        root;
    logic [3:0]  root_idx;
    logic [1:0]  root_cnt;
    logic [1:0]  cnt_final;
    logic        fail_end;
    logic [14:0] r_flip;
    logic [14:0] div_w, raw_w;
    logic [6:0]  div_q, rawq_next;
    logic        bad;

    assign in_ready      = (state_q == StIdle) && !rst;
    assign out_valid     = (state_q == StDone);
    assign msg_out       = msg_q;
    assign err_cnt       = errcnt_q;
    assign uncorrectable = unc_q;

    // Peterson solution for t=2 from the latched syndromes.
    always_comb begin
        s1_cube  = gf16_mul(gf16_mul(s1_q, s1_q, POLY), s1_q, POLY);
        sig1     = s1_q;
        sig2     = '0;
        loc_exp  = 2'd0;
        loc_fail = 1'b0;
        if (s1_q == 4'h0) begin
            loc_fail = (s3_q != 4'h0);
        end else if (s3_q == s1_cube) begin
            loc_exp = 2'd1;
        end else begin
            sig2    = gf16_mul(s3_q, gf16_inv(s1_q), POLY) ^ gf16_mul(s1_q, s1_q, POLY);
            loc_exp = 2'd2;
        end
    end

    bch_chien_search #(
        .PRIM_POLY(PRIM_POLY)
    ) u_chien (
        .clk     (clk),
        .rst     (rst),
        .start   (state_q == StLocate),
        .sig1    (sig1),
        .sig2    (sig2),
        .root    (root),
        .idx     (root_idx),
        .root_cnt(root_cnt)
    );

    // Correction flip for this Chien step and one long-division step for both dividends.
    always_comb begin
        r_flip    = r_q;
        if (root && !fail_q) begin
            r_flip = r_q ^ (15'h0001 << root_idx);
        end
        cnt_final = root_cnt + {1'b0, root};
        fail_end  = fail_q || (cnt_final != exp_q);
        div_w     = (r_q ^ (r_q[14] ? G_TOP : 15'h0000)) << 1;
        div_q     = {q_q[5:0], r_q[14]};
        raw_w     = (raw_q ^ (raw_q[14] ? G_TOP : 15'h0000)) << 1;
        rawq_next = {qraw_q[5:0], raw_q[14]};
        bad       = fail_q || (div_w[14:7] != 8'h00);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; the phase lengths give a fixed 38-edge latency.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (in_valid) state_d = StSynd;
            StSynd:   if (cnt_q == 4'd0) state_d = StLocate;
            StLocate: state_d = StChien;
            StChien:  if (cnt_q == 4'd0) state_d = StDivide;
            StDivide: if (cnt_q == 4'd0) state_d = StDone;
            StDone:   if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath registers for each decode phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            r_q      <= '0;
            raw_q    <= '0;
            s1_q     <= '0;
            s3_q     <= '0;
            exp_q    <= '0;
            fail_q   <= 1'b0;
            err_q    <= '0;
            q_q      <= '0;
            qraw_q   <= '0;
            msg_q    <= '0;
            errcnt_q <= '0;
            unc_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        r_q   <= cw_in;
                        raw_q <= cw_in;
                        s1_q  <= '0;
                        s3_q  <= '0;
                        cnt_q <= 4'd14;
                    end
                end
                StSynd: begin
                    s1_q  <= gf16_mul(s1_q, A1, POLY) ^ {3'b000, r_q[cnt_q]};
                    s3_q  <= gf16_mul(s3_q, A3, POLY) ^ {3'b000, r_q[cnt_q]};
                    cnt_q <= cnt_q - 4'd1;
                end
                StLocate: begin
                    exp_q  <= loc_exp;
                    fail_q <= loc_fail;
                    cnt_q  <= 4'd14;
                end
                StChien: begin
                    if (cnt_q == 4'd0) begin
                        // Last step: a root-count mismatch discards all flips.
                        r_q    <= fail_end ? raw_q : r_flip;
                        fail_q <= fail_end;
                        err_q  <= cnt_final;
                        cnt_q  <= 4'd6;
                    end else begin
                        r_q   <= r_flip;
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDivide: begin
                    r_q    <= div_w;
                    raw_q  <= raw_w;
                    q_q    <= div_q;
                    qraw_q <= rawq_next;
                    cnt_q  <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        unc_q    <= bad;
                        errcnt_q <= bad ? 2'd0 : err_q;
                        msg_q    <= !bad ? div_q : (PASS_RAW_ON_FAIL ? rawq_next : 7'h00);
                    end
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
